prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter DW, default 9, giving the instruction/data word width.
REQ-002 The block SHALL have parameter AW, default 4, giving the program address width; the program store depth is 2**AW.
REQ-003 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 Port LoadEn, input, 1 bit: program-store write strobe.
REQ-006 Port LoadAddr, input, AW bits: program-store write address.
REQ-007 Port LoadData, input, DW bits: program-store write data.
REQ-008 Port LastAddr, input, AW bits: address of the final program word, sampled on Start.
REQ-009 Port Start, input, 1 bit: begin execution at address 0.
REQ-010 Port Done, input, 1 bit: instruction-complete strobe from the processor.
REQ-011 Port DIN, output, DW bits: word presented to the processor.
REQ-012 Port Run, output, 1 bit: high while a program is executing.
REQ-013 Port ProcResetn, output, 1 bit: active-low step-counter clear to the processor.
REQ-014 Port PC, output, AW bits: address of the current instruction.
REQ-015 Port Busy, output, 1 bit: high when not in IDLE or HALT.
REQ-016 Port Finished, output, 1 bit: sticky flag, program completed normally.
REQ-017 Port Error, output, 1 bit: sticky flag, program aborted.

Function
REQ-018 The program store SHALL be 2**AW x DW; the write occurs at the clock edge when LoadEn=1 and Busy=0, and it is ignored when Busy=1.
REQ-019 The FSM SHALL have states IDLE, FETCH, IMM, WAIT and HALT.
REQ-020 IDLE SHALL drive DIN=0, Run=0 and ProcResetn=0; on Start=1 it latches LastAddr, sets PC=0, clears Finished and Error, and goes to FETCH.
REQ-021 FETCH SHALL drive DIN=mem[PC], Run=1 and ProcResetn=1; this is processor step T0, and the state lasts exactly 1 cycle.
REQ-022 FETCH SHALL go to IMM if mem[PC][DW-1:DW-3]=001 (mvi), and to WAIT otherwise.
REQ-023 IMM SHALL drive DIN=mem[PC+1]; Done=1 completes the instruction with PC advancing by 2, and Done=0 aborts.
REQ-024 An mvi located at PC=LastAddr or at PC=2**AW-1 SHALL abort in FETCH, since it has no immediate word.
REQ-025 WAIT SHALL hold DIN=mem[PC]; Done=1 completes the instruction with PC advancing by 1.
REQ-026 WAIT SHALL run a 3-bit timeout counter that is cleared on entry; if the 4th consecutive WAIT cycle has no Done, the block aborts (covers opcodes 100-111).
REQ-027 On completion, if the completed instruction's last word was at LastAddr, the block SHALL go to HALT with Finished=1; otherwise it SHALL go to FETCH with the next cycle at processor T0.
REQ-028 Abort SHALL go to HALT with Error=1, holding PC at the faulting instruction.
REQ-029 HALT SHALL drive Run=0, DIN=0 and ProcResetn=0, and SHALL hold the Finished, Error and PC values.
REQ-030 HALT SHALL go to FETCH on Start=1 (same actions as in IDLE) and SHALL ignore Done.
REQ-031 PC arithmetic SHALL be modulo 2**AW; wrap is unreachable because of REQ-024 and REQ-027.
REQ-032 Done SHALL be ignored in IDLE, FETCH and HALT, and Start SHALL be ignored while Busy=1.
REQ-033 A simultaneous LoadEn and Start in IDLE SHALL perform the write first; the first FETCH reads the updated contents.
REQ-034 Instruction latency SHALL be: mv and mvi 2 cycles each; add and sub 4 cycles each (FETCH plus 3 WAIT).

Reset
REQ-035 When Resetn=0 at a clock edge, the block SHALL enter IDLE with DIN=0, Run=0, ProcResetn=0, PC=0, Busy=0, Finished=0, Error=0, the timeout counter at 0, and latched LastAddr at 0.
REQ-036 A reset asserted during any state, including mid-instruction, SHALL abort without setting flags, and program-store contents SHALL be retained.

Verification
REQ-037 The bench SHALL load 0:001000000, 1:000000101, 2:000001000, LastAddr=2, pulse Start, and model Done per REQ-034 -> DIN sequence 001000000, 000000101, 000001000, 000001000; Finished=1 after 4 active cycles; Error=0.
REQ-038 The bench SHALL run an add at 0 with LastAddr=0 and Done on the 3rd WAIT cycle -> Run high 4 cycles, then HALT with Finished=1.
REQ-039 The bench SHALL run opcode 101 at address 0 with Done held 0 -> Error=1 after 1 FETCH plus 4 WAIT cycles; PC=0.
REQ-040 The bench SHALL place an mvi at LastAddr=3 -> Error=1 in the FETCH cycle at PC=3; no DIN presentation of address 4.
REQ-041 The bench SHALL assert LoadEn while Busy=1 -> memory unchanged; the same write after HALT succeeds and is read on the next Start.
REQ-042 The bench SHALL drive Resetn=0 during the 2nd WAIT cycle of an add -> next cycle IDLE, all outputs at reset values, and a rerun yields the same DIN sequence.

Source files
------------

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Holds a small program store and feeds its words, one instruction at a
//   time, to a simple multi-cycle processor. It supplies the T0 step-counter
//   clear, waits for the processor's Done strobe, and reports normal completion
//   or abort through sticky flags.
//
// Parameters
//   DW  instruction/data word width; the opcode is the top three bits
//   AW  program address width; the store holds 2**AW words
//
// Ports
//   Clock       rising-edge clock
//   Resetn      synchronous active-low reset (program store is retained)
//   LoadEn      program-store write strobe, honoured only while not Busy
//   LoadAddr    program-store write address
//   LoadData    program-store write data
//   LastAddr    address of the final program word, captured on Start
//   Start       begin execution at address 0 (ignored while Busy)
//   Done        instruction-complete strobe from the processor
//   DIN         word presented to the processor
//   Run         high while a program is executing
//   ProcResetn  active-low step-counter clear to the processor
//   PC          address of the current instruction
//   Busy        high in FETCH, IMM and WAIT
//   Finished    sticky: program ran to LastAddr
//   Error       sticky: program aborted
// ---------------------------------------------------------------------------
module prog_sequencer #(
   parameter int unsigned DW = 9,
   parameter int unsigned AW = 4
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          LoadEn,
   input  logic [AW-1:0] LoadAddr,
   input  logic [DW-1:0] LoadData,
   input  logic [AW-1:0] LastAddr,
   input  logic          Start,
   input  logic          Done,
   output logic [DW-1:0] DIN,
   output logic          Run,
   output logic          ProcResetn,
   output logic [AW-1:0] PC,
   output logic          Busy,
   output logic          Finished,
   output logic          Error
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned SW    = 3;
   localparam int unsigned TW    = 3;
   localparam int unsigned OPW   = 3;

   localparam logic [SW-1:0] S_IDLE  = 3'd0;
   localparam logic [SW-1:0] S_FETCH = 3'd1;
   localparam logic [SW-1:0] S_IMM   = 3'd2;
   localparam logic [SW-1:0] S_WAIT  = 3'd3;
   localparam logic [SW-1:0] S_HALT  = 3'd4;

   localparam logic [OPW-1:0] OP_MVI   = 3'b001;
   // Value of the timeout counter during the 4th consecutive WAIT cycle
   localparam logic [TW-1:0]  TMO_LAST = 3'd3;
   localparam logic [AW-1:0]  ADDR_MAX = {AW{1'b1}};

   logic [DW-1:0]  mem [DEPTH];

   logic [SW-1:0]  state_q, state_d;
   logic [AW-1:0]  last_q, last_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [AW-1:0]  pc_d;
   logic           fin_d, err_d;
   logic           act_d;
   logic [DW-1:0]  din_d;

   logic           wr_en;
   logic [OPW-1:0] cur_op;
   logic [AW-1:0]  pc_plus1, pc_plus2;
   logic [AW-1:0]  din_addr;
   logic [DW-1:0]  din_word;

   // Writes are locked out while a program is executing
   assign wr_en    = LoadEn & ~Busy;
   assign cur_op   = mem[PC][DW-1 -: OPW];
   assign pc_plus1 = PC + AW'(1);
   assign pc_plus2 = PC + AW'(2);

   // Program store (no reset: contents survive Resetn)
   always_ff @(posedge Clock) begin
      if (wr_en) begin
         mem[LoadAddr] <= LoadData;
      end
   end

   // Next-state, PC and flag logic
   always_comb begin
      state_d = state_q;
      pc_d    = PC;
      last_d  = last_q;
      tmo_d   = tmo_q;
      fin_d   = Finished;
      err_d   = Error;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (Start) begin
               state_d = S_FETCH;
               pc_d    = '0;
               last_d  = LastAddr;
               fin_d   = 1'b0;
               err_d   = 1'b0;
            end
         end

         S_FETCH: begin
            tmo_d = '0;
            if (cur_op == OP_MVI) begin
               // An mvi with no following immediate word cannot complete
               if ((PC == last_q) || (PC == ADDR_MAX)) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_IMM;
               end
            end else begin
               state_d = S_WAIT;
            end
         end

         S_IMM: begin
            if (Done) begin
               if (pc_plus1 == last_q) begin
                  state_d = S_HALT;
                  fin_d   = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = pc_plus2;
               end
            end else begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end
         end

         S_WAIT: begin
            if (Done) begin
               if (PC == last_q) begin
                  state_d = S_HALT;
                  fin_d   = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = pc_plus1;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Word for the next cycle's DIN; bypasses a same-edge write so a Start
   // issued together with LoadEn sees the new contents in its first FETCH.
   always_comb begin
      act_d    = (state_d == S_FETCH) || (state_d == S_IMM) || (state_d == S_WAIT);
      din_addr = (state_d == S_IMM) ? (pc_d + AW'(1)) : pc_d;
      if (wr_en && (LoadAddr == din_addr)) begin
         din_word = LoadData;
      end else begin
         din_word = mem[din_addr];
      end
      din_d = act_d ? din_word : '0;
   end

   // State and registered outputs
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         last_q     <= '0;
         tmo_q      <= '0;
         PC         <= '0;
         Finished   <= 1'b0;
         Error      <= 1'b0;
         DIN        <= '0;
         Run        <= 1'b0;
         ProcResetn <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         tmo_q      <= tmo_d;
         PC         <= pc_d;
         Finished   <= fin_d;
         Error      <= err_d;
         DIN        <= din_d;
         Run        <= act_d;
         ProcResetn <= act_d;
         Busy       <= act_d;
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//   Directed bench for prog_sequencer with hand-computed expectations.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at the same point, so each observation shows the state entered at the
//   preceding edge.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

   localparam int unsigned DW = 9;
   localparam int unsigned AW = 4;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic          LoadEn;
   logic [AW-1:0] LoadAddr;
   logic [DW-1:0] LoadData;
   logic [AW-1:0] LastAddr;
   logic          Start;
   logic          Done;
   logic [DW-1:0] DIN;
   logic          Run;
   logic          ProcResetn;
   logic [AW-1:0] PC;
   logic          Busy;
   logic          Finished;
   logic          Error;

   int checks   = 0;
   int failures = 0;

   localparam logic [DW-1:0] W_ADD  = 9'b010000001;
   localparam logic [DW-1:0] W_MVI  = 9'b001000000;
   localparam logic [DW-1:0] W_MV7  = 9'b000000111;

   prog_sequencer #(.DW(DW), .AW(AW)) dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .LoadEn     (LoadEn),
      .LoadAddr   (LoadAddr),
      .LoadData   (LoadData),
      .LastAddr   (LastAddr),
      .Start      (Start),
      .Done       (Done),
      .DIN        (DIN),
      .Run        (Run),
      .ProcResetn (ProcResetn),
      .PC         (PC),
      .Busy       (Busy),
      .Finished   (Finished),
      .Error      (Error)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      LoadEn   = 1'b1;
      LoadAddr = a;
      LoadData = d;
      tick();
      LoadEn   = 1'b0;
   endtask

   task automatic go(input logic [AW-1:0] la);
      LastAddr = la;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_din"},  16'(DIN),        16'h0);
      check({tag, "_run"},  16'(Run),        16'h0);
      check({tag, "_prn"},  16'(ProcResetn), 16'h0);
      check({tag, "_pc"},   16'(PC),         16'h0);
      check({tag, "_busy"}, 16'(Busy),       16'h0);
      check({tag, "_fin"},  16'(Finished),   16'h0);
      check({tag, "_err"},  16'(Error),      16'h0);
   endtask

   initial begin
      Resetn = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
      LastAddr = '0; Start = 1'b0; Done = 1'b0;
      tick(); tick();
      check_idle("reset");
      Resetn = 1'b1;
      tick();

      // mvi 0,#5 then mv: DIN sequence mvi, imm, mv, mv
      load(4'd0, 9'b001000000);
      load(4'd1, 9'b000000101);
      load(4'd2, 9'b000001000);
      Done = 1'b1;
      go(4'd2);
      check("p1_f0_din",  16'(DIN),        16'h040);
      check("p1_f0_run",  16'(Run),        16'h1);
      check("p1_f0_prn",  16'(ProcResetn), 16'h1);
      check("p1_f0_busy", 16'(Busy),       16'h1);
      check("p1_f0_pc",   16'(PC),         16'h0);
      tick();
      check("p1_imm_din", 16'(DIN),        16'h005);
      check("p1_imm_pc",  16'(PC),         16'h0);
      tick();
      check("p1_f2_din",  16'(DIN),        16'h008);
      check("p1_f2_pc",   16'(PC),         16'h2);
      tick();
      check("p1_w2_din",  16'(DIN),        16'h008);
      check("p1_w2_busy", 16'(Busy),       16'h1);
      tick();
      check("p1_h_fin",   16'(Finished),   16'h1);
      check("p1_h_err",   16'(Error),      16'h0);
      check("p1_h_run",   16'(Run),        16'h0);
      check("p1_h_din",   16'(DIN),        16'h0);
      tick();
      check("p1_h_hold",  16'(Finished),   16'h1);
      check("p1_h_idle",  16'(Busy),       16'h0);

      // add at 0, Done on 3rd WAIT; Start during WAIT ignored
      load(4'd0, W_ADD);
      Done = 1'b0;
      go(4'd0);
      check("p2_f_run",   16'(Run),        16'h1);
      check("p2_f_fin",   16'(Finished),   16'h0);
      tick();
      check("p2_w1_run",  16'(Run),        16'h1);
      tick();
      check("p2_w2_run",  16'(Run),        16'h1);
      tick();
      check("p2_w3_run",  16'(Run),        16'h1);
      check("p2_w3_din",  16'(DIN),        16'(W_ADD));
      Done = 1'b1; Start = 1'b1;
      tick();
      Done = 1'b0; Start = 1'b0;
      check("p2_h_run",   16'(Run),        16'h0);
      check("p2_h_fin",   16'(Finished),   16'h1);
      check("p2_h_busy",  16'(Busy),       16'h0);

      // opcode 101 with no Done: timeout after FETCH + 4 WAIT
      load(4'd0, 9'b101000000);
      go(4'd0);
      tick(); tick(); tick(); tick();
      check("p3_w4_busy", 16'(Busy),       16'h1);
      check("p3_w4_err",  16'(Error),      16'h0);
      tick();
      check("p3_h_err",   16'(Error),      16'h1);
      check("p3_h_pc",    16'(PC),         16'h0);
      check("p3_h_fin",   16'(Finished),   16'h0);
      check("p3_h_busy",  16'(Busy),       16'h0);

      // three mv then mvi at LastAddr=3: abort in FETCH
      load(4'd0, 9'b000000001);
      load(4'd1, 9'b000000010);
      load(4'd2, 9'b000000011);
      load(4'd3, W_MVI);
      load(4'd4, 9'b111111111);
      Done = 1'b1;
      go(4'd3);
      tick(); tick(); tick(); tick(); tick(); tick();
      check("p4_f3_pc",   16'(PC),         16'h3);
      check("p4_f3_din",  16'(DIN),        16'(W_MVI));
      check("p4_f3_run",  16'(Run),        16'h1);
      tick();
      check("p4_h_err",   16'(Error),      16'h1);
      check("p4_h_pc",    16'(PC),         16'h3);
      check("p4_h_din",   16'(DIN),        16'h0);
      check("p4_h_fin",   16'(Finished),   16'h0);
      Done = 1'b0;

      // write while Busy is dropped; write after HALT lands
      load(4'd0, W_ADD);
      go(4'd0);
      tick();
      LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = W_MV7;
      tick();
      LoadEn = 1'b0;
      tick();
      check("p5_w3_din",  16'(DIN),        16'(W_ADD));
      Done = 1'b1;
      tick();
      check("p5_h_fin",   16'(Finished),   16'h1);
      go(4'd0);
      check("p5_rerun",   16'(DIN),        16'(W_ADD));
      tick(); tick();
      check("p5_h2_fin",  16'(Finished),   16'h1);
      load(4'd0, W_MV7);
      go(4'd0);
      check("p5_new_din", 16'(DIN),        16'(W_MV7));
      tick(); tick();
      check("p5_h3_fin",  16'(Finished),   16'h1);
      Done = 1'b0;

      // reset during 2nd WAIT of an add, then rerun
      load(4'd0, W_ADD);
      go(4'd0);
      tick(); tick();
      Resetn = 1'b0;
      tick();
      check_idle("p6_rst");
      Resetn = 1'b1;
      go(4'd0);
      check("p6_f_din",   16'(DIN),        16'(W_ADD));
      tick();
      check("p6_w1_din",  16'(DIN),        16'(W_ADD));
      tick();
      check("p6_w2_din",  16'(DIN),        16'(W_ADD));
      tick();
      check("p6_w3_din",  16'(DIN),        16'(W_ADD));
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("p6_h_fin",   16'(Finished),   16'h1);

      // LoadEn together with Start in IDLE: first FETCH sees the new word
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 9'b000000101;
      go(4'd0);
      LoadEn = 1'b0;
      check("p7_f_din",   16'(DIN),        16'h005);
      check("p7_f_busy",  16'(Busy),       16'h1);
      Done = 1'b1;
      tick(); tick();
      Done = 1'b0;
      check("p7_h_fin",   16'(Finished),   16'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
